alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational ALU in the execute stage between two requesters: port 0 is the instruction execute path and port 1 is the auxiliary address/stack-pointer path. It arbitrates round-robin, drives the ALU operands and function code, and registers the result in a one-deep response buffer with a valid/ready handshake. It also owns the architectural condition-code register, which is updated only by granted requests that carry `set_cc`.

## Interface
- `W`, 64, operand and result width; it must match the ALU width.
- `PRIO_RESET`, 0, the requester that wins the first contention after reset.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_a` / `req1_a`  in  W  ALU `input1`.
- `req0_b` / `req1_b`  in  W  ALU `input2`.
- `req0_fun` / `req1_fun`  in  4  function: 0 = add, 1 = sub (b−a), 2 = and, 3 = xor.
- `req0_setcc` / `req1_setcc`  in  1  commit the ALU flags to `cc`.
- `alu_input1`, `alu_input2`  out  W  to the ALU.
- `alu_fun`  out  4  to the ALU.
- `alu_valE`  in  W  from the ALU, combinational.
- `alu_cc`  in  3  from the ALU, ordered {ZF, SF, OF}.
- `rsp_valid`  out  1  response buffered.
- `rsp_id`  out  1  requester that owns the response.
- `rsp_valE`  out  W  result.
- `rsp_err`  out  1  illegal function code.
- `rsp_ready`  in  1  consumer takes the response.
- `cc`  out  3  condition-code register, ordered {ZF, SF, OF}.

## Operation
- State: `last_grant` (1 bit), a response buffer (`rsp_valid`, `rsp_id`, `rsp_valE`, `rsp_err`), and `cc`.
- `can_accept = !rsp_valid || rsp_ready`.
- Grant logic:
  - Only port 0 valid: grant 0.
  - Only port 1 valid: grant 1.
  - Both valid: grant `!last_grant`.
  - `reqN_ready = can_accept && granted(N)`.
  - At most one ready per cycle.
  - Ready may depend combinationally on valid.
- ALU drive:
  - `alu_*` follow the granted port's operands.
  - When no port is granted, `alu_*` hold port 0's operands, so the ALU always sees a defined `fun`.
- On accept (valid && ready), at the clock edge:
  - `rsp_valid <= 1`, `rsp_id <= N`, `last_grant <= N`.
  - If `fun` ≤ 3: `rsp_valE <= alu_valE`, `rsp_err <= 0`, and `cc <= alu_cc` when `setcc` is set.
  - If `fun` ≥ 4: `rsp_valE <= 0`, `rsp_err <= 1`, `cc` is unchanged regardless of `setcc`, and `alu_valE`/`alu_cc` are ignored.
- On `rsp_valid && rsp_ready` with no new accept: `rsp_valid <= 0`. The other buffer fields hold their values.
- Simultaneous consume and accept: the buffer is overwritten with the new response and `rsp_valid` stays 1. Throughput is one operation per cycle.
- Response held (`rsp_valid && !rsp_ready`):
  - Both readies are 0.
  - Requesters must hold `valid` and their operands stable.
  - `last_grant` does not change.
- Requests that are not granted are not consumed. There is no starvation: under continuous contention the grant alternates every accept.

## Timing
- Reset values:
  - `rsp_valid = 0`, `rsp_id = 0`, `rsp_valE = 0`, `rsp_err = 0`.
  - `cc = 3'b100` (ZF = 1).
  - `last_grant = !PRIO_RESET`.
  - `req*_ready` are combinational; they are 0 during a reset cycle.
- Reset mid-operation: a pending response is dropped and any request presented in the reset cycle is not accepted.
- Latency: a request accepted at edge N appears as `rsp_valid` and `rsp_valE` after edge N. The `cc` update becomes visible after the same edge.
- Combinational paths:
  - `reqN_valid`/`rsp_ready` → `reqN_ready`.
  - `req*` operands → `alu_*` → `alu_valE`/`alu_cc` → buffer D-inputs.
  - No combinational path from `rsp_ready` to `rsp_valE`.
- Arithmetic is the ALU's own: W-bit wraparound, with no carry out. The arbiter adds no arithmetic.

## Test plan
- **Single add:** after reset, `req0 = {a=5, b=7, fun=0, setcc=1}` with `rsp_ready=1`. Require `req0_ready=1` in that cycle; next cycle `rsp_valid=1`, `rsp_id=0`, `rsp_valE=12`, `rsp_err=0`, `cc=3'b000`.
- **Round-robin:** both ports valid for 4 cycles, `PRIO_RESET=0`, `rsp_ready=1`. Require the grant sequence 0, 1, 0, 1 and `rsp_id` to follow it one cycle later.
- **Backpressure:** `rsp_ready=0` for 3 cycles after the first accept. Require both readies at 0 and `rsp_valE` stable. When `rsp_ready` rises with `req1` waiting, `req1` is accepted in that same cycle.
- **Flags and setcc:** `sub` with a=1, b=1, `setcc=1` gives `valE=0` and `cc=3'b100`. Then add with a=0x7FFF_FFFF_FFFF_FFFF, b=1, `setcc=0` gives `valE=0x8000_0000_0000_0000` and `cc` remains 3'b100. The same add with `setcc=1` gives `cc=3'b011`.
- **Illegal function:** `fun=4`, `setcc=1`. Require `rsp_err=1`, `rsp_valE=0`, and `cc` unchanged.
- **Reset mid-operation:** assert `rst` while `rsp_valid=1` and `rsp_ready=0`. Require after the next edge `rsp_valid=0`, `cc=3'b100`, and the first grant on contention going to `PRIO_RESET`.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters, with a
// one-deep registered response buffer and the architectural condition-code register.
module alu_arbiter #(
    parameter int unsigned W          = 64,
    parameter bit          PRIO_RESET = 1'b0
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [3:0]   req0_fun,
    input  logic         req0_setcc,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [3:0]   req1_fun,
    input  logic         req1_setcc,

    output logic [W-1:0] alu_input1,
    output logic [W-1:0] alu_input2,
    output logic [3:0]   alu_fun,
    input  logic [W-1:0] alu_valE,
    input  logic [2:0]   alu_cc,

    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [W-1:0] rsp_valE,
    output logic         rsp_err,
    input  logic         rsp_ready,

    output logic [2:0]   cc
);

    logic last_grant;
    logic can_accept;
    logic sel;
    logic sel_setcc;
    logic accept;
    logic fun_ok;

    always_comb begin
        can_accept = !rsp_valid || rsp_ready;

        // With no requester, sel stays 0 so the ALU sees port 0's operands.
        if (req0_valid && req1_valid) begin
            sel = !last_grant;
        end else begin
            sel = req1_valid;
        end

        req0_ready = !rst && can_accept && req0_valid && !sel;
        req1_ready = !rst && can_accept && req1_valid && sel;
        accept     = req0_ready || req1_ready;

        if (sel) begin
            alu_input1 = req1_a;
            alu_input2 = req1_b;
            alu_fun    = req1_fun;
            sel_setcc  = req1_setcc;
        end else begin
            alu_input1 = req0_a;
            alu_input2 = req0_b;
            alu_fun    = req0_fun;
            sel_setcc  = req0_setcc;
        end

        fun_ok = (alu_fun <= 4'd3);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_valE   <= '0;
            rsp_err    <= 1'b0;
            cc         <= 3'b100;
            last_grant <= !PRIO_RESET;
        end else if (accept) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= sel;
            last_grant <= sel;
            if (fun_ok) begin
                rsp_valE <= alu_valE;
                rsp_err  <= 1'b0;
                if (sel_setcc) begin
                    cc <= alu_cc;
                end
            end else begin
                // Illegal code: ALU outputs are meaningless and must not reach state.
                rsp_valE <= '0;
                rsp_err  <= 1'b1;
            end
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table from the test plan, then randomized
// traffic checked against a transaction-level reference model.
module tb_alu_arbiter;

    localparam int unsigned W          = 64;
    localparam bit          PRIO_RESET = 1'b0;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  fun;
        logic        setcc;
    } req_t;

    typedef struct {
        logic        rst;
        logic        v0;
        req_t        p0;
        logic        v1;
        req_t        p1;
        logic        rr;
        int          g;
        logic        rv;
        logic        rid;
        logic [63:0] val;
        logic        err;
        logic [2:0]  cc;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]   req0_fun, req1_fun;
    logic         req0_setcc, req1_setcc;
    logic [W-1:0] alu_input1, alu_input2, alu_valE;
    logic [3:0]   alu_fun;
    logic [2:0]   alu_cc;
    logic         rsp_valid, rsp_id, rsp_err, rsp_ready;
    logic [W-1:0] rsp_valE;
    logic [2:0]   cc;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic        m_valid;
    logic        m_id;
    logic [63:0] m_val;
    logic        m_err;
    logic [2:0]  m_cc;
    int          m_pref;

    always #5 clk = ~clk;

    alu_arbiter #(.W(W), .PRIO_RESET(PRIO_RESET)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_fun(req0_fun), .req0_setcc(req0_setcc),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_fun(req1_fun), .req1_setcc(req1_setcc),
        .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_fun(alu_fun),
        .alu_valE(alu_valE), .alu_cc(alu_cc),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_valE(rsp_valE), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready), .cc(cc)
    );

    // Execute-stage ALU; emits junk for illegal codes so leakage is visible.
    always_comb begin
        logic [63:0] r;
        logic        of;
        r  = 64'hdead_beef_0bad_f00d;
        of = 1'b0;
        case (alu_fun)
            4'd0: begin
                r  = alu_input1 + alu_input2;
                of = (alu_input1[63] == alu_input2[63]) && (r[63] != alu_input1[63]);
            end
            4'd1: begin
                r  = alu_input2 - alu_input1;
                of = (alu_input1[63] != alu_input2[63]) && (r[63] != alu_input2[63]);
            end
            4'd2: r = alu_input1 & alu_input2;
            4'd3: r = alu_input1 ^ alu_input2;
            default: ;
        endcase
        alu_valE = r;
        alu_cc   = (alu_fun <= 4'd3) ? {r == 64'd0, r[63], of} : 3'b111;
    end

    function automatic req_t rq(input logic [63:0] a, input logic [63:0] b,
                                input logic [3:0] fun, input logic sc);
        req_t p;
        p.a = a; p.b = b; p.fun = fun; p.setcc = sc;
        return p;
    endfunction

    // Result and flags from signed wide arithmetic rather than sign-bit tricks.
    function automatic void ref_op(input req_t p, output logic [63:0] v,
                                   output logic [2:0] f, output logic ok);
        logic signed [65:0] sa, sb, wide, sv;
        sa = {{2{p.a[63]}}, p.a};
        sb = {{2{p.b[63]}}, p.b};
        ok = 1'b1;
        wide = '0;
        case (p.fun)
            4'd0: wide = sa + sb;
            4'd1: wide = sb - sa;
            4'd2: wide = sa & sb;
            4'd3: wide = sa ^ sb;
            default: ok = 1'b0;
        endcase
        v  = ok ? wide[63:0] : 64'd0;
        sv = {{2{v[63]}}, v};
        f  = {v == 64'd0, v[63], wide != sv};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Called at a negedge: drive inputs, check readies, advance model, check outputs.
    task automatic cycle(input logic r, input logic v0, input req_t p0, input logic v1,
                         input req_t p1, input logic rr, output int g,
                         output logic rd0, output logic rd1);
        logic [63:0] v;
        logic [2:0]  f;
        logic        ok;
        req_t        p;
        rst = r; rsp_ready = rr;
        req0_valid = v0; req0_a = p0.a; req0_b = p0.b; req0_fun = p0.fun; req0_setcc = p0.setcc;
        req1_valid = v1; req1_a = p1.a; req1_b = p1.b; req1_fun = p1.fun; req1_setcc = p1.setcc;
        #1;
        g = -1;
        if (!r && (!m_valid || rr)) begin
            if (v0 && v1) g = m_pref;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end
        rd0 = req0_ready; rd1 = req1_ready;
        chk("req0_ready", {63'd0, req0_ready}, {63'd0, g == 0});
        chk("req1_ready", {63'd0, req1_ready}, {63'd0, g == 1});
        if (r) begin
            m_valid = 0; m_id = 0; m_val = 0; m_err = 0; m_cc = 3'b100; m_pref = PRIO_RESET;
        end else if (g >= 0) begin
            p = (g == 1) ? p1 : p0;
            ref_op(p, v, f, ok);
            m_valid = 1; m_id = (g == 1); m_val = v; m_err = !ok;
            if (ok && p.setcc) m_cc = f;
            m_pref = 1 - g;
        end else if (m_valid && rr) begin
            m_valid = 0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_valid});
        chk("rsp_id",    {63'd0, rsp_id},    {63'd0, m_id});
        chk("rsp_valE",  rsp_valE,           m_val);
        chk("rsp_err",   {63'd0, rsp_err},   {63'd0, m_err});
        chk("cc",        {61'd0, cc},        {61'd0, m_cc});
    endtask

    function automatic vec_t mk(input logic r, input logic v0, input req_t p0, input logic v1,
                                input req_t p1, input logic rr, input int g, input logic rv,
                                input logic rid, input logic [63:0] val, input logic err,
                                input logic [2:0] c);
        vec_t t;
        t.rst = r; t.v0 = v0; t.p0 = p0; t.v1 = v1; t.p1 = p1; t.rr = rr; t.g = g;
        t.rv = rv; t.rid = rid; t.val = val; t.err = err; t.cc = c;
        return t;
    endfunction

    initial begin
        vec_t        vecs[$];
        req_t        z, rr0, rr1, big, q0, q1;
        int          g;
        logic        rd0, rd1;
        logic        k0, k1;
        logic [63:0] neg7;

        z    = rq(64'd0, 64'd0, 4'd0, 1'b0);
        rr0  = rq(64'd1, 64'd2, 4'd0, 1'b0);
        rr1  = rq(64'd10, 64'd3, 4'd1, 1'b0);
        big  = rq(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd0, 1'b0);
        neg7 = 64'hFFFF_FFFF_FFFF_FFF9;

        //                rst v0 p0                          v1 p1                     rr  g  rv rid val     err cc
        vecs.push_back(mk(1, 0, z,                          0, z,                      1, -1, 0, 0, 64'd0, 0, 3'b100));
        vecs.push_back(mk(0, 1, rq(5, 7, 0, 1),             0, z,                      1,  0, 1, 0, 64'd12, 0, 3'b000));
        vecs.push_back(mk(1, 0, z,                          0, z,                      1, -1, 0, 0, 64'd0, 0, 3'b100));
        vecs.push_back(mk(0, 1, rr0,                        1, rr1,                    1,  0, 1, 0, 64'd3, 0, 3'b100));
        vecs.push_back(mk(0, 1, rr0,                        1, rr1,                    1,  1, 1, 1, neg7,  0, 3'b100));
        vecs.push_back(mk(0, 1, rr0,                        1, rr1,                    1,  0, 1, 0, 64'd3, 0, 3'b100));
        vecs.push_back(mk(0, 1, rr0,                        1, rr1,                    1,  1, 1, 1, neg7,  0, 3'b100));
        vecs.push_back(mk(0, 1, rq(4, 4, 3, 0),             0, z,                      1,  0, 1, 0, 64'd0, 0, 3'b100));
        vecs.push_back(mk(0, 0, z,                          1, rq(6, 3, 2, 0),         0, -1, 1, 0, 64'd0, 0, 3'b100));
        vecs.push_back(mk(0, 0, z,                          1, rq(6, 3, 2, 0),         0, -1, 1, 0, 64'd0, 0, 3'b100));
        vecs.push_back(mk(0, 0, z,                          1, rq(6, 3, 2, 0),         0, -1, 1, 0, 64'd0, 0, 3'b100));
        vecs.push_back(mk(0, 0, z,                          1, rq(6, 3, 2, 0),         1,  1, 1, 1, 64'd2, 0, 3'b100));
        vecs.push_back(mk(0, 1, rq(1, 1, 1, 1),             0, z,                      1,  0, 1, 0, 64'd0, 0, 3'b100));
        vecs.push_back(mk(0, 1, big,                        0, z,                      1,  0, 1, 0, 64'h8000_0000_0000_0000, 0, 3'b100));
        vecs.push_back(mk(0, 1, rq(big.a, 1, 0, 1),         0, z,                      1,  0, 1, 0, 64'h8000_0000_0000_0000, 0, 3'b011));
        vecs.push_back(mk(0, 0, z,                          1, rq(3, 4, 4, 1),         1,  1, 1, 1, 64'd0, 1, 3'b011));
        vecs.push_back(mk(0, 1, rq(1, 1, 0, 0),             1, rq(2, 2, 0, 0),         0, -1, 1, 1, 64'd0, 1, 3'b011));
        vecs.push_back(mk(1, 1, rq(1, 1, 0, 0),             1, rq(2, 2, 0, 0),         0, -1, 0, 0, 64'd0, 0, 3'b100));
        vecs.push_back(mk(0, 1, rq(2, 2, 0, 0),             1, rq(9, 9, 0, 0),         1,  0, 1, 0, 64'd4, 0, 3'b100));

        rst = 1; rsp_ready = 0;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_fun = 0; req0_setcc = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_fun = 0; req1_setcc = 0;
        m_valid = 0; m_id = 0; m_val = 0; m_err = 0; m_cc = 3'b100; m_pref = PRIO_RESET;
        @(negedge clk);

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].v0, vecs[i].p0, vecs[i].v1, vecs[i].p1, vecs[i].rr,
                  g, rd0, rd1);
            chk($sformatf("vec%0d grant0", i), {63'd0, rd0}, {63'd0, vecs[i].g == 0});
            chk($sformatf("vec%0d grant1", i), {63'd0, rd1}, {63'd0, vecs[i].g == 1});
            chk($sformatf("vec%0d rsp_valid", i), {63'd0, rsp_valid}, {63'd0, vecs[i].rv});
            chk($sformatf("vec%0d rsp_id", i), {63'd0, rsp_id}, {63'd0, vecs[i].rid});
            chk($sformatf("vec%0d rsp_valE", i), rsp_valE, vecs[i].val);
            chk($sformatf("vec%0d rsp_err", i), {63'd0, rsp_err}, {63'd0, vecs[i].err});
            chk($sformatf("vec%0d cc", i), {61'd0, cc}, {61'd0, vecs[i].cc});
        end

        // Random traffic; an un-granted request is held stable until accepted.
        k0 = 0; k1 = 0; q0 = z; q1 = z;
        for (int n = 0; n < 400; n++) begin
            if (!k0) begin
                k0 = ($urandom_range(0, 2) != 0);
                q0 = rq({$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? 64'd1 : {$urandom, $urandom},
                        4'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
            end
            if (!k1) begin
                k1 = ($urandom_range(0, 2) != 0);
                q1 = rq({$urandom, $urandom}, {$urandom, $urandom},
                        4'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
            end
            cycle(($urandom_range(0, 49) == 0), k0, q0, k1, q1, ($urandom_range(0, 3) != 0),
                  g, rd0, rd1);
            if (g == 0 || rst) k0 = 0;
            if (g == 1 || rst) k1 = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
